// File: rtl/ysyx_23060203_axi_rd_xbar_pkg.sv
// Shared types and constants for the AXI read/write crossbars.
//   state_e  : crossbar FSM states
//   target_e : address-decode result
//   RESP_*   : AXI response codes used by the crossbar
//   DEF_*    : default address windows
//   in_window: 33-bit window test, so base+size never wraps
package ysyx_23060203_xbar_pkg;

  typedef enum logic [1:0] {IDLE, AR, R, ERR} state_e;
  typedef enum logic [1:0] {TGT_CLINT, TGT_MEM, TGT_ERR} target_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] DEF_CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] DEF_CLINT_SIZE = 32'h0001_0000;
  localparam logic [31:0] DEF_MEM_BASE   = 32'h8000_0000;
  localparam logic [31:0] DEF_MEM_SIZE   = 32'h0800_0000;

  // base <= a < base+size, computed with a carry bit so a window reaching
  // the top of the address space still has a correct upper bound.
  function automatic logic in_window(input logic [31:0] a,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] x, lo, hi;
    x  = {1'b0, a};
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/ysyx_23060203_axi_rd_xbar_if.sv
// AXI read-channel bundle (AR + R).
//   in  : view of the block that accepts reads (slave side)
//   out : view of the block that issues reads (master side)
interface ysyx_23060203_axi_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  modport in  (input  arvalid, araddr, arid, arlen, rready,
               output arready, rvalid, rdata, rresp, rid, rlast);
  modport out (output arvalid, araddr, arid, arlen, rready,
               input  arready, rvalid, rdata, rresp, rid, rlast);
endinterface

// File: rtl/ysyx_23060203_axi_rd_xbar_addr_dec.sv
// Combinational address decoder shared by the read and write crossbars.
//   addr : byte address to decode
//   tgt  : TGT_CLINT / TGT_MEM when inside a window, TGT_ERR otherwise
module ysyx_23060203_addr_dec
  import ysyx_23060203_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_SIZE = DEF_CLINT_SIZE,
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic [31:0] addr,
  output target_e     tgt
);

  always_comb begin
    tgt = TGT_ERR;
    if (in_window(addr, CLINT_BASE, CLINT_SIZE))
      tgt = TGT_CLINT;
    else if (in_window(addr, MEM_BASE, MEM_SIZE))
      tgt = TGT_MEM;
  end

endmodule

// File: rtl/ysyx_23060203_axi_rd_xbar.sv
// Read-channel crossbar: one master port to CLINT and main memory.
// One outstanding read; the AR is registered before being forwarded, the
// returned beats carry the master's ARID, and unmapped reads are answered
// locally with a DECERR burst of arlen+1 beats.
//   clock, reset : clock, synchronous active-high reset
//   up           : master side (core LSU/IFU)
//   clint        : CLINT uptime device
//   mem          : main memory
module ysyx_23060203_axi_rd_xbar
  import ysyx_23060203_xbar_pkg::*;
#(
  parameter logic [31:0] CLINT_BASE = DEF_CLINT_BASE,
  parameter logic [31:0] CLINT_SIZE = DEF_CLINT_SIZE,
  parameter logic [31:0] MEM_BASE   = DEF_MEM_BASE,
  parameter logic [31:0] MEM_SIZE   = DEF_MEM_SIZE
) (
  input  logic              clock,
  input  logic              reset,
  ysyx_23060203_axi_if.in   up,
  ysyx_23060203_axi_if.out  clint,
  ysyx_23060203_axi_if.out  mem
);

  state_e      state;
  target_e     tgt, dec_tgt;
  logic        arready_q;
  logic [31:0] addr_q;
  logic [3:0]  id_q;
  logic [7:0]  len_q, cnt_q;
  logic        sel_arready, up_rhs;

  // Slave rid is replaced by the latched master id.
  logic        unused_rid;
  assign unused_rid = ^{clint.rid, mem.rid};

  ysyx_23060203_addr_dec #(
    .CLINT_BASE(CLINT_BASE), .CLINT_SIZE(CLINT_SIZE),
    .MEM_BASE(MEM_BASE),     .MEM_SIZE(MEM_SIZE)
  ) u_dec (
    .addr(up.araddr),
    .tgt (dec_tgt)
  );

  assign sel_arready = (tgt == TGT_CLINT) ? clint.arready : mem.arready;
  assign up_rhs      = up.rvalid && up.rready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tgt       <= TGT_ERR;
      arready_q <= 1'b0;
      addr_q    <= '0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          arready_q <= 1'b1;
          if (up.arvalid && arready_q) begin
            addr_q    <= up.araddr;
            id_q      <= up.arid;
            len_q     <= up.arlen;
            cnt_q     <= up.arlen;
            tgt       <= dec_tgt;
            arready_q <= 1'b0;
            state     <= (dec_tgt == TGT_ERR) ? ERR : AR;
          end
        end
        AR: if (sel_arready) state <= R;
        R: if (up_rhs && up.rlast) begin
          state     <= IDLE;
          arready_q <= 1'b1;
        end
        ERR: if (up.rready) begin
          if (cnt_q == 8'd0) begin
            state     <= IDLE;
            arready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Master-facing outputs: zero outside R/ERR so idle values are clean.
  always_comb begin
    up.arready = arready_q;
    up.rvalid  = 1'b0;
    up.rdata   = '0;
    up.rresp   = RESP_OKAY;
    up.rid     = '0;
    up.rlast   = 1'b0;
    case (state)
      R: begin
        up.rid = id_q;
        if (tgt == TGT_CLINT) begin
          up.rvalid = clint.rvalid;
          up.rdata  = clint.rdata;
          up.rresp  = clint.rresp;
          up.rlast  = clint.rlast;
        end else begin
          up.rvalid = mem.rvalid;
          up.rdata  = mem.rdata;
          up.rresp  = mem.rresp;
          up.rlast  = mem.rlast;
        end
      end
      ERR: begin
        up.rvalid = 1'b1;
        up.rresp  = RESP_DECERR;
        up.rid    = id_q;
        up.rlast  = (cnt_q == 8'd0);
      end
      default: ;
    endcase
  end

  // Slave-facing outputs come only from registers, never from up.ar*.
  always_comb begin
    clint.araddr  = addr_q;
    clint.arid    = id_q;
    clint.arlen   = len_q;
    mem.araddr    = addr_q;
    mem.arid      = id_q;
    mem.arlen     = len_q;
    clint.arvalid = (state == AR) && (tgt == TGT_CLINT);
    mem.arvalid   = (state == AR) && (tgt == TGT_MEM);
    clint.rready  = (state == R)  && (tgt == TGT_CLINT) && up.rready;
    mem.rready    = (state == R)  && (tgt == TGT_MEM)   && up.rready;
  end

endmodule

// File: doc/ysyx_23060203_axi_rd_xbar.md
# ysyx_23060203_axi_rd_xbar

Read-channel AXI crossbar between the core's LSU/IFU read port and the two read targets: the CLINT uptime device and main memory. It registers each accepted read address, decodes it to a target, and forwards the transaction with one outstanding read at a time. It restores the master's ARID on every returned beat and answers unmapped addresses locally with a DECERR burst.

## Interface
Parameters:
- CLINT_BASE, 32'h0200_0000, CLINT window base
- CLINT_SIZE, 32'h0001_0000, CLINT window size in bytes
- MEM_BASE, 32'h8000_0000, memory window base
- MEM_SIZE, 32'h0800_0000, memory window size in bytes

Ports:
- clock  in  1  single clock; all state on posedge
- reset  in  1  synchronous, active-high
- up  ysyx_23060203_axi_if.in  bundle  master side: araddr 32, arid 4, arlen 8, rdata 32, rresp 2, rid 4, rlast 1, valid/ready pairs
- clint  ysyx_23060203_axi_if.out  bundle  to CLINT
- mem  ysyx_23060203_axi_if.out  bundle  to memory

Write channels are not handled by this block.

## Operation
- States: IDLE, AR, R, ERR.
- **IDLE**
  - up.arready=1.
  - On up.arvalid&&arready: latch araddr/arid/arlen and decode the target.
  - Decode: CLINT if CLINT_BASE<=addr<CLINT_BASE+CLINT_SIZE; MEM on the same rule with the MEM window; otherwise ERR.
  - Next state: AR for CLINT/MEM, ERR otherwise.
- **AR**
  - Selected slave: arvalid=1, with latched araddr, arlen and arid.
  - Hold arvalid until slave arready, then go to R.
  - up.arready=0.
- **R**
  - Selected slave's rvalid/rdata/rresp/rlast go to up. Master rready goes to that slave.
  - up.rid = latched arid. Slave rid is ignored, since CLINT returns 0.
  - On up.rvalid&&rready&&rlast, go to IDLE.
- **ERR**
  - Drive up.rvalid=1, rdata=0, rresp=2'b11 (DECERR), rid=latched arid.
  - An 8-bit beat counter loads arlen and decrements on each handshake.
  - rlast = (counter==0). Handshake with rlast returns to IDLE.
- The unselected slave always sees arvalid=0 and rready=0. In IDLE and ERR both slaves see arvalid=0 and rready=0.
- Address arithmetic is done in 33 bits so base+size never wraps. Address exactly equal to base+size is unmapped.

## Timing
- Reset values:
  - state=IDLE.
  - up.arready=0 while reset is high, 1 on the first cycle after.
  - up.rvalid=0, up.rlast=0, up.rresp=0, up.rid=0, up.rdata=0.
  - All slave arvalid=0 and rready=0.
- Latency with a zero-wait slave (e.g. CLINT, which is always ready and valid):
  - cycle 0: up AR handshake.
  - cycle 1: slave AR handshake.
  - cycle 2: first up.rvalid.
- ERR latency: up.rvalid rises the cycle after the up AR handshake.
- Throughput: a new up AR can be accepted in the cycle after the last R handshake. No overlap with the previous transaction.
- Back-pressure:
  - up.rready=0 stalls R/ERR indefinitely.
  - rdata, rresp, rid and rlast stay stable while up.rvalid&&!rready.
- Slave arready low holds AR indefinitely, with the address stable.
- Reset mid-transaction returns to IDLE the next cycle and drops all valids. In-flight beats are discarded and slaves are reset by the same reset.
- No combinational path from up.arvalid to any slave signal.

## Structure
- Package ysyx_23060203_xbar_pkg:
  - state enum {IDLE, AR, R, ERR}
  - target enum {TGT_CLINT, TGT_MEM, TGT_ERR}
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11
  - default window constants
- Sub-module ysyx_23060203_addr_dec: purely combinational; parameterised windows in, address in, target enum out. It is reused later by the write-side crossbar.
- Top holds the FSM, the latched AR fields, the ERR beat counter and the R mux.

## Test plan
- Read 0x0200_0000, arid=5, arlen=0, rready=1:
  - CLINT sees araddr 0x0200_0000 in cycle 1.
  - up gets rdata=uptime[31:0], rresp=0, rid=5, rlast=1 in cycle 2.
  - Then back to IDLE.
- Read 0x0200_0004 twice in succession: upper uptime word is returned. Second arready rises the cycle after the first rlast handshake.
- Read 0x8000_0010, arlen=3, mem arready delayed 3 cycles, rready toggling 1/0:
  - Exactly 4 beats reach up in order, rlast on the 4th only.
  - Data is held stable during each stall.
- Read 0x0000_1000, arid=9, arlen=2:
  - No slave arvalid.
  - 3 beats with rresp=3, rdata=0, rid=9, rlast on the 3rd.
- Boundary addresses:
  - 0x0201_0000 and 0x8800_0000 give DECERR.
  - 0x0200_FFFC routes to CLINT, 0x87FF_FFFC routes to MEM.
- Assert reset during the 2nd beat of a 4-beat mem read:
  - Next cycle up.rvalid=0, mem rready=0, up.arready=1 after reset drops.
  - A following CLINT read completes normally.
